// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy (pending producer) bits, two registered
// read ports with write bypass, and a one-register-per-cycle clear sweep FSM.
module regfile_scoreboard #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy, busy_upd, busy_nxt;
  logic              sweep_en, wr_eff, claim_eff;
  logic [DATA_W-1:0] byp_data_a, byp_data_b;
  logic              byp_busy_a, byp_busy_b;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = SWEEP;
      SWEEP:   if (idx == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sweep_en  = (state == SWEEP);
    clr_busy  = sweep_en;
    dbg_state = (state == SWEEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        idx <= '0;
    else if (sweep_en) idx <= idx + ADDR_W'(1);
    else               idx <= '0;
  end

  // Producers are locked out while the sweep owns the array.
  always_comb begin
    wr_eff    = wr_en    && !sweep_en && !is_r0(wr_addr);
    claim_eff = claim_en && !sweep_en && !is_r0(claim_addr);
  end

  // busy_upd is what readers see (claim wins over write); the sweep only
  // affects the stored value so reads during a sweep show current contents.
  always_comb begin
    busy_upd = busy;
    if (wr_eff)    busy_upd[wr_addr]    = 1'b0;
    if (claim_eff) busy_upd[claim_addr] = 1'b1;
    busy_nxt = busy_upd;
    if (sweep_en)     busy_nxt[idx] = 1'b0;
    if (ZERO_R0 != 0) busy_nxt[0]   = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sweep_en && idx == ADDR_W'(i))
          mem[i] <= '0;
        else if (wr_eff && wr_addr == ADDR_W'(i))
          mem[i] <= wr_data;
      end
      busy <= busy_nxt;
    end
  end

  always_comb begin
    byp_data_a = '0;
    byp_busy_a = 1'b0;
    if (!is_r0(rd_addr_a)) begin
      byp_data_a = (wr_eff && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
      byp_busy_a = busy_upd[rd_addr_a];
    end
  end

  always_comb begin
    byp_data_b = '0;
    byp_busy_b = 1'b0;
    if (!is_r0(rd_addr_b)) begin
      byp_data_b = (wr_eff && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];
      byp_busy_b = busy_upd[rd_addr_b];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_busy_a <= 1'b0;
      rd_busy_b <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= byp_data_a;
        rd_data_b <= byp_data_b;
        rd_busy_a <= byp_busy_a;
        rd_busy_b <= byp_busy_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one default instance and one with
// ZERO_R0=1, both driven by the same stimulus.
module tb_regfile_scoreboard;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          claim_en = 1'b0;
  logic [AW-1:0] claim_addr = '0;
  logic          clr_req = 1'b0;

  logic [DW-1:0] d0_a, d0_b, d1_a, d1_b;
  logic          b0_a, b0_b, b1_a, b1_b;
  logic          v0, v1, cb0, cb1, st0, st1;

  int vec  = 0;
  int miss = 0;
  int cnt;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) u0 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d0_a), .rd_data_b(d0_b), .rd_busy_a(b0_a), .rd_busy_b(b0_b), .rd_valid(v0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .clr_req(clr_req), .clr_busy(cb0), .dbg_state(st0)
  );

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) u1 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d1_a), .rd_data_b(d1_b), .rd_busy_a(b1_a), .rd_busy_b(b1_b), .rd_valid(v1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .clr_req(clr_req), .clr_busy(cb1), .dbg_state(st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd_en = 1'b0; wr_en = 1'b0; claim_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    quiet();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
    rd_en = 1'b1; rd_addr_a = a; rd_addr_b = b;
    tick();
    quiet();
  endtask

  initial begin
    #12;
    chk("reset_valid", v0, 0);
    chk("reset_data_a", d0_a, 0);
    chk("reset_busy_b", b0_b, 0);
    chk("reset_clr_busy", cb0, 0);
    chk("reset_state", st0, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    // write then read back one cycle later
    do_write(3'd5, 16'h1234);
    do_read(3'd5, 3'd5);
    chk("rd5_valid", v0, 1);
    chk("rd5_data_a", d0_a, 16'h1234);
    chk("rd5_busy_a", b0_a, 0);
    tick();
    chk("idle_valid_low", v0, 0);
    chk("idle_data_hold", d0_a, 16'h1234);

    // same-cycle write/read bypass on both ports
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    rd_en = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    tick();
    quiet();
    chk("byp_data_a", d0_a, 16'hBEEF);
    chk("byp_data_b", d0_b, 16'hBEEF);
    chk("byp_busy_a", b0_a, 0);
    chk("byp_busy_b", b0_b, 0);

    // claim / write interaction on r2
    claim_en = 1'b1; claim_addr = 3'd2;
    tick();
    quiet();
    do_read(3'd2, 3'd5);
    chk("claim_busy_a", b0_a, 1);
    chk("claim_busy_b", b0_b, 0);
    chk("claim_data_a", d0_a, 0);
    do_write(3'd2, 16'h0007);
    do_read(3'd2, 3'd2);
    chk("wr_clears_busy", b0_a, 0);
    chk("wr_data_r2", d0_a, 16'h0007);
    claim_en = 1'b1; claim_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0055;
    tick();
    quiet();
    do_read(3'd2, 3'd2);
    chk("claim_wins_busy", b0_a, 1);
    chk("claim_wins_data", d0_a, 16'h0055);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0066;
    rd_en = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    tick();
    quiet();
    chk("byp_post_wr_busy", b0_a, 0);
    chk("byp_post_wr_data", d0_b, 16'h0066);

    // register zero behaviour
    do_write(3'd0, 16'hFFFF);
    claim_en = 1'b1; claim_addr = 3'd0;
    tick();
    quiet();
    do_read(3'd0, 3'd0);
    chk("z1_data_a", d1_a, 0);
    chk("z1_busy_a", b1_a, 0);
    chk("z0_data_a", d0_a, 16'hFFFF);
    chk("z0_busy_a", b0_a, 1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hABCD;
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    tick();
    quiet();
    chk("z1_byp_data_b", d1_b, 0);
    chk("z1_byp_busy_b", b1_b, 0);
    chk("z0_byp_data_b", d0_b, 16'hABCD);

    // fill, then clear sweep with writes attempted throughout
    for (int i = 0; i < 8; i++) do_write(AW'(i), 16'h1000 + DW'(i) * 16'h0111);
    clr_req = 1'b1;
    tick();
    quiet();
    cnt = 0;
    for (int k = 0; k < 20 && cb0; k++) begin
      cnt++;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hDEAD;
      claim_en = 1'b1; claim_addr = 3'd6;
      rd_en = (k == 0); rd_addr_a = 3'd7;
      tick();
      if (k == 0) chk("sweep_read_r7", d0_a, 16'h1777);
    end
    quiet();
    chk("sweep_cycles", cnt, 8);
    chk("sweep_done_clr_busy", cb0, 0);
    chk("sweep_done_state", st0, 0);
    for (int i = 0; i < 8; i++) begin
      do_read(AW'(i), AW'(i));
      chk($sformatf("cleared_data_r%0d", i), d0_a, 0);
      chk($sformatf("cleared_busy_r%0d", i), b0_b, 0);
    end

    // back-to-back sweep accepted, then reset mid-sweep and mid-read
    do_write(3'd1, 16'h4242);
    clr_req = 1'b1;
    tick();
    quiet();
    chk("resweep_clr_busy", cb0, 1);
    rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd5;
    tick();
    chk("midsweep_data_a", d0_a, 16'h4242);
    chk("midsweep_valid", v0, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_data_a", d0_a, 0);
    chk("arst_valid", v0, 0);
    chk("arst_clr_busy", cb0, 0);
    chk("arst_state", st0, 0);
    tick();
    chk("arst_hold_data", d0_a, 0);
    quiet();
    @(negedge clk) reset = 1'b1;
    tick();
    chk("post_rst_clr_busy", cb0, 0);
    do_read(3'd1, 3'd5);
    chk("post_rst_r1", d0_a, 0);
    chk("post_rst_r5", d0_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads as zero, ignores writes, and is never busy.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state changes on rising edge
  reset  in  1  asynchronous, active-low reset
  rd_en  in  1  read request, both ports
  rd_addr_a  in  ADDR_W  read port A address
  rd_addr_b  in  ADDR_W  read port B address
  rd_data_a  out  DATA_W  registered read data, port A
  rd_data_b  out  DATA_W  registered read data, port B
  rd_busy_a  out  1  registered busy flag of rd_addr_a
  rd_busy_b  out  1  registered busy flag of rd_addr_b
  rd_valid  out  1  rd_data_*/rd_busy_* valid this cycle
  wr_en  in  1  write enable
  wr_addr  in  ADDR_W  write address
  wr_data  in  DATA_W  write data
  claim_en  in  1  mark a register busy (pending producer)
  claim_addr  in  ADDR_W  register to mark busy
  clr_req  in  1  start clear sweep
  clr_busy  out  1  clear sweep in progress

Function
REQ-005 SHALL store DEPTH registers of DATA_W bits plus one busy bit per register.
REQ-006 SHALL return read data one cycle after rd_en=1: rd_valid=1 in the following cycle, else 0.
REQ-007 SHALL hold rd_data_*/rd_busy_* unchanged when rd_en=0.
REQ-008 SHALL write wr_data into reg[wr_addr] at the rising edge when wr_en=1, and clear busy[wr_addr] at the same edge.
REQ-009 SHALL bypass: same-cycle rd_en and wr_en with rd_addr_x==wr_addr return wr_data on rd_data_x and report busy as its post-write value.
REQ-010 SHALL set busy[claim_addr] at the rising edge when claim_en=1.
REQ-011 SHALL give claim precedence over write when claim_addr==wr_addr in the same cycle: data written, busy ends at 1.
REQ-012 SHALL, with ZERO_R0=1, return 0 and busy=0 for address 0 on either port, including bypass cases.
REQ-013 SHALL implement FSM IDLE/SWEEP: IDLE->SWEEP on clr_req=1; SWEEP zeroes reg[idx] and busy[idx], one register per cycle, idx 0 to DEPTH-1; SWEEP->IDLE after idx DEPTH-1.
REQ-014 SHALL assert clr_busy in every SWEEP cycle (exactly DEPTH cycles), deasserted in IDLE.
REQ-015 SHALL ignore wr_en, claim_en, and clr_req during SWEEP; reads during SWEEP return current array contents.
REQ-016 SHALL wrap sweep index with no out-of-range access; the next clr_req is accepted the cycle after SWEEP ends.

Reset
REQ-017 SHALL, while reset=0, asynchronously clear all registers, all busy bits, rd_data_a/b=0, rd_busy_a/b=0, rd_valid=0, clr_busy=0, FSM=IDLE, sweep index=0.
REQ-018 SHALL abort a sweep in progress on reset assertion and resume in IDLE on release, at the first rising edge with reset=1.

Verification
REQ-019 Write 16'h1234 to r5; next cycle rd_en with addr_a=5 -> rd_valid=1, rd_data_a=16'h1234 one cycle later.
REQ-020 Same cycle: wr_en r3=16'hBEEF and rd_en addr_a=3, addr_b=3 -> both ports return 16'hBEEF, busy=0.
REQ-021 claim r2, read r2 -> rd_busy_a=1; write r2=16'h0007 -> later read shows busy=0, data 16'h0007; claim+write r2 same cycle -> busy=1, data written.
REQ-022 ZERO_R0=1: write r0=16'hFFFF, claim r0, read r0 -> rd_data_a=0, rd_busy_a=0.
REQ-023 Fill all 8 registers, pulse clr_req -> clr_busy high exactly 8 cycles, wr_en during sweep ignored, all reads 0 afterwards.
REQ-024 Assert reset low mid-sweep and mid-read -> all outputs 0 immediately, FSM IDLE, clr_busy=0.
